bus_ctrl_sequencer: RTL and testbench

Multi-cycle control sequencer that drives the 32-bit datapath bus. Each cycle it raises at most one bit of a one-hot source-select vector, which the bus encoder/multiplexer turns into the bus driver. It also asserts the matching register-load strobes, stepping fetch (T0–T2) and execute (T3–T5) for register-register ALU ops, ADDI and HALT. It sits directly upstream of the bus and is the only producer of the `*out` selects.

---
 rtl/bus_ctrl_pkg.sv | 47 ++++
 rtl/bus_ctrl_decode.sv | 92 +++++++++
 rtl/bus_ctrl_sequencer.sv | 75 +++++++
 tb/tb_bus_ctrl_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_ctrl_pkg.sv
// Shared encodings for the bus control sequencer: states, opcodes, bus source
// indices and ALU operation codes.
package bus_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
  } state_e;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;

  // Opcodes that run the execute phase; everything else (HALT included) halts.
  function automatic logic is_exec_op(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_ADDI);
  endfunction

  function automatic logic [2:0] alu_of(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI: return ALU_ADD;
      OP_SUB:          return ALU_SUB;
      OP_AND:          return ALU_AND;
      OP_OR:           return ALU_OR;
      default:         return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/bus_ctrl_decode.sv
// Combinational strobe decode: maps sequencer state, IR fields and the
// first-T1-cycle flag onto the one-hot bus select and register load strobes.
module bus_ctrl_decode
  import bus_ctrl_pkg::*;
(
  input  state_e      state,
  input  logic [31:0] ir,
  input  logic        t1_first,
  output logic [31:0] src_sel,
  output logic [15:0] reg_in,
  output logic        pc_in,
  output logic        ir_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        y_in,
  output logic        z_in,
  output logic        inc_pc,
  output logic        mem_read,
  output logic [2:0]  alu_op,
  output logic        done,
  output logic        halted
);

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       unused_ir;

  assign op        = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];

  always_comb begin
    src_sel  = '0;
    reg_in   = '0;
    pc_in    = 1'b0;
    ir_in    = 1'b0;
    mar_in   = 1'b0;
    mdr_in   = 1'b0;
    y_in     = 1'b0;
    z_in     = 1'b0;
    inc_pc   = 1'b0;
    mem_read = 1'b0;
    alu_op   = ALU_PASS;
    done     = 1'b0;
    halted   = 1'b0;
    case (state)
      S_T0: begin
        src_sel[SRC_PC] = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      S_T1: begin
        mem_read = 1'b1;
        mdr_in   = 1'b1;
        // PC+1 is written back once; wait cycles only hold the read request.
        if (t1_first) begin
          src_sel[SRC_ZLO] = 1'b1;
          pc_in = 1'b1;
        end
      end
      S_T2: begin
        src_sel[SRC_MDR] = 1'b1;
        ir_in = 1'b1;
      end
      S_T3: begin
        src_sel[{1'b0, rb}] = 1'b1;
        y_in = 1'b1;
      end
      S_T4: begin
        z_in = 1'b1;
        if (op == OP_ADDI) begin
          src_sel[SRC_C] = 1'b1;
          alu_op = ALU_ADD;
        end else begin
          src_sel[{1'b0, rc}] = 1'b1;
          alu_op = alu_of(op);
        end
      end
      S_T5: begin
        src_sel[SRC_ZLO] = 1'b1;
        reg_in[ra] = 1'b1;
        done = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_ctrl_sequencer.sv
// Fetch/execute control sequencer: state register, first-T1 flag and
// next-state logic; all strobes come from bus_ctrl_decode.
module bus_ctrl_sequencer
  import bus_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        clear_n,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [31:0] src_sel,
  output logic [15:0] reg_in,
  output logic        pc_in,
  output logic        ir_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        y_in,
  output logic        z_in,
  output logic        inc_pc,
  output logic        mem_read,
  output logic [2:0]  alu_op,
  output logic        done,
  output logic        halted
);

  state_e state_q, state_d;
  logic   t1_first_q, t1_first_d;

  always_comb begin
    state_d    = state_q;
    // T0 always proceeds to T1, so this marks exactly the entry cycle.
    t1_first_d = (state_q == S_T0);
    case (state_q)
      S_IDLE:  if (run) state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    if (mem_ready) state_d = S_T2;
      S_T2:    state_d = is_exec_op(ir[31:27]) ? S_T3 : S_HALT;
      S_T3:    state_d = S_T4;
      S_T4:    state_d = S_T5;
      S_T5:    state_d = run ? S_T0 : S_IDLE;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q    <= S_IDLE;
      t1_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      t1_first_q <= t1_first_d;
    end
  end

  bus_ctrl_decode u_decode (
    .state    (state_q),
    .ir       (ir),
    .t1_first (t1_first_q),
    .src_sel  (src_sel),
    .reg_in   (reg_in),
    .pc_in    (pc_in),
    .ir_in    (ir_in),
    .mar_in   (mar_in),
    .mdr_in   (mdr_in),
    .y_in     (y_in),
    .z_in     (z_in),
    .inc_pc   (inc_pc),
    .mem_read (mem_read),
    .alu_op   (alu_op),
    .done     (done),
    .halted   (halted)
  );

endmodule

// File: tb/tb_bus_ctrl_sequencer.sv
// Scoreboard bench for bus_ctrl_sequencer: expected per-cycle output vectors are
// queued when an instruction is launched and popped as the DUT steps.
module tb_bus_ctrl_sequencer;

  logic        clock = 1'b0;
  logic        clear_n, run, mem_ready;
  logic [31:0] ir;
  logic [31:0] src_sel;
  logic [15:0] reg_in;
  logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, inc_pc, mem_read;
  logic [2:0]  alu_op;
  logic        done, halted;

  int total = 0;
  int bad   = 0;

  logic [60:0] exp_q[$];
  logic [60:0] obs;

  localparam logic [7:0] PC = 8'h80, IRI = 8'h40, MAR = 8'h20, MDR = 8'h10;
  localparam logic [7:0] Y  = 8'h08, Z   = 8'h04, INC = 8'h02, MRD = 8'h01;

  always #5 clock = ~clock;

  bus_ctrl_sequencer dut (
    .clock(clock), .clear_n(clear_n), .run(run), .ir(ir), .mem_ready(mem_ready),
    .src_sel(src_sel), .reg_in(reg_in), .pc_in(pc_in), .ir_in(ir_in),
    .mar_in(mar_in), .mdr_in(mdr_in), .y_in(y_in), .z_in(z_in), .inc_pc(inc_pc),
    .mem_read(mem_read), .alu_op(alu_op), .done(done), .halted(halted)
  );

  assign obs = {src_sel, reg_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in,
                inc_pc, mem_read, alu_op, done, halted};

  function automatic logic [60:0] mk(input int src, input int rg, input logic [7:0] str,
                                     input logic [2:0] alu, input logic dn, input logic hl);
    logic [31:0] s;
    logic [15:0] r;
    s = '0;
    r = '0;
    if (src >= 0) s[src] = 1'b1;
    if (rg >= 0) r[rg] = 1'b1;
    return {s, r, str, alu, dn, hl};
  endfunction

  // Reference expectation for one complete instruction with `waits` stalled T1 cycles.
  task automatic push_instr(input logic [31:0] i, input int waits);
    logic [2:0] a;
    case (i[31:27])
      5'b00011, 5'b01100: a = 3'd1;
      5'b00100:           a = 3'd2;
      5'b00101:           a = 3'd3;
      5'b00110:           a = 3'd4;
      default:            a = 3'd0;
    endcase
    exp_q.push_back(mk(20, -1, MAR | INC | Z, 3'd0, 1'b0, 1'b0));
    exp_q.push_back(mk(19, -1, PC | MRD | MDR, 3'd0, 1'b0, 1'b0));
    for (int w = 0; w < waits; w++) exp_q.push_back(mk(-1, -1, MRD | MDR, 3'd0, 1'b0, 1'b0));
    exp_q.push_back(mk(21, -1, IRI, 3'd0, 1'b0, 1'b0));
    exp_q.push_back(mk(int'(i[22:19]), -1, Y, 3'd0, 1'b0, 1'b0));
    exp_q.push_back(mk((i[31:27] == 5'b01100) ? 23 : int'(i[18:15]), -1, Z, a, 1'b0, 1'b0));
    exp_q.push_back(mk(19, int'(i[26:23]), 8'h00, 3'd0, 1'b1, 1'b0));
  endtask

  // One-hot invariant on every live cycle.
  always @(negedge clock) begin
    if (clear_n === 1'b1) begin
      total++;
      if ($countones(src_sel) > 1 || $countones(reg_in) > 1) begin
        bad++;
        $display("FAIL onehot src_sel=%h reg_in=%h", src_sel, reg_in);
      end
    end
  end

  task automatic test_reset;
    #1;
    total++;
    if (obs !== 61'd0) begin bad++; $display("FAIL reset_async got=%h want=0", obs); end
    @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);
    total++;
    if (obs !== 61'd0) begin bad++; $display("FAIL reset_idle got=%h want=0", obs); end
  endtask

  task automatic test_add;
    logic [60:0] e;
    ir = 32'h1989_0000;
    push_instr(ir, 0);
    exp_q.push_back(61'd0);
    run = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL add cyc%0d got=%h want=%h", c, obs, e); end
      if (c == 0) run = 1'b0;
    end
  endtask

  task automatic test_add_wait;
    logic [60:0] e;
    int npc, nmr;
    npc = 0;
    nmr = 0;
    ir = 32'h1989_0000;
    push_instr(ir, 3);
    exp_q.push_back(61'd0);
    run = 1'b1;
    mem_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL add_wait cyc%0d got=%h want=%h", c, obs, e); end
      npc += int'(pc_in);
      nmr += int'(mem_read);
      mem_ready = (c >= 4);
      if (c == 0) run = 1'b0;
    end
    total++;
    if (npc !== 1) begin bad++; $display("FAIL pc_in_pulses got=%0d want=1", npc); end
    total++;
    if (nmr !== 4) begin bad++; $display("FAIL mem_read_cycles got=%0d want=4", nmr); end
  endtask

  task automatic test_addi;
    logic [60:0] e;
    ir = {5'b01100, 4'd5, 4'd5, 19'h0_0123};
    push_instr(ir, 0);
    exp_q.push_back(61'd0);
    run = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL addi cyc%0d got=%h want=%h", c, obs, e); end
      if (c == 0) run = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    logic [60:0] e;
    ir = {5'b00100, 4'd4, 4'd6, 4'd7, 15'h0};
    for (int n = 0; n < 3; n++) push_instr(ir, 0);
    exp_q.push_back(61'd0);
    run = 1'b1;
    for (int c = 0; c < 19; c++) begin
      @(negedge clock);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL b2b cyc%0d got=%h want=%h", c, obs, e); end
      if (c == 12) run = 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    logic [60:0] e;
    ir = 32'h1989_0000;
    push_instr(ir, 0);
    void'(exp_q.pop_back());
    run = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL rmid_pre cyc%0d got=%h want=%h", c, obs, e); end
    end
    #2 clear_n = 1'b0;
    #1;
    total++;
    if (obs !== 61'd0) begin bad++; $display("FAIL rmid_async got=%h want=0", obs); end
    @(negedge clock);
    clear_n = 1'b1;
    exp_q.push_back(mk(20, -1, MAR | INC | Z, 3'd0, 1'b0, 1'b0));
    @(negedge clock);
    e = exp_q.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("FAIL rmid_first_t0 got=%h want=%h", obs, e); end
    run = 1'b0;
    clear_n = 1'b0;
    #1 clear_n = 1'b1;
  endtask

  task automatic test_halt;
    logic [60:0] e;
    ir = 32'hF800_0000;
    exp_q.push_back(mk(20, -1, MAR | INC | Z, 3'd0, 1'b0, 1'b0));
    exp_q.push_back(mk(19, -1, PC | MRD | MDR, 3'd0, 1'b0, 1'b0));
    exp_q.push_back(mk(21, -1, IRI, 3'd0, 1'b0, 1'b0));
    for (int h = 0; h < 5; h++) exp_q.push_back(mk(-1, -1, 8'h00, 3'd0, 1'b0, 1'b1));
    run = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL halt cyc%0d got=%h want=%h", c, obs, e); end
      if (c >= 2) run = ~run;
    end
    clear_n = 1'b0;
    run = 1'b0;
    #1;
    total++;
    if (obs !== 61'd0) begin bad++; $display("FAIL halt_clear got=%h want=0", obs); end
    clear_n = 1'b1;
    @(negedge clock);
    total++;
    if (obs !== 61'd0) begin bad++; $display("FAIL halt_exit_idle got=%h want=0", obs); end
  endtask

  initial begin
    clear_n   = 1'b0;
    run       = 1'b0;
    mem_ready = 1'b1;
    ir        = '0;
    test_reset;
    test_add;
    test_add_wait;
    test_addi;
    test_back_to_back;
    test_reset_mid;
    test_halt;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
